// File: rtl/or_32bit_checker_if.sv
// Sample/result bundle between a stimulus source and the OR checker.
interface or_32bit_checker_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_res;
  logic             chk_valid;
  logic             chk_ok;

  modport master (
    output in_valid, in_a, in_b, in_res,
    input  chk_valid, chk_ok
  );

  modport slave (
    input  in_valid, in_a, in_b, in_res,
    output chk_valid, chk_ok
  );
endinterface

// File: rtl/or_32bit_checker.sv
// Response monitor for the 32-bit OR unit: per-sample verdict, saturating counters, sticky FSM.
// Define OR_CHECKER_CAPTURE_EN to build the first-mismatch capture registers.
module or_32bit_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  or_32bit_checker_if.slave    bus,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err,
  output logic [1:0]           state,
  output logic                 first_valid,
  output logic [WIDTH-1:0]     first_a,
  output logic [WIDTH-1:0]     first_b,
  output logic [WIDTH-1:0]     first_res,
  output logic [WIDTH-1:0]     first_exp
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PASSING = 2'b01,
    FAILED  = 2'b10
  } state_t;

  state_t st_p1;
  state_t st_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage 0: expected value and verdict on the incoming sample
  logic [WIDTH-1:0] exp_p0;
  logic             ok_p0;
  logic             accept_p0;

  assign exp_p0    = bus.in_a | bus.in_b;
  assign ok_p0     = (bus.in_res == exp_p0);
  assign accept_p0 = bus.in_valid & ~clear;

  always_comb begin
    st_nxt = st_p1;
    if (accept_p0) begin
      case (st_p1)
        IDLE, PASSING: st_nxt = ok_p0 ? PASSING : FAILED;
        default:       st_nxt = FAILED;
      endcase
    end
  end

  // Stage 1: registered verdict, counters and FSM
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bus.chk_valid <= 1'b0;
      bus.chk_ok    <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      st_p1         <= IDLE;
      err           <= 1'b0;
    end else begin
      bus.chk_valid <= accept_p0;
      if (accept_p0) begin
        bus.chk_ok <= ok_p0;
        if (ok_p0) pass_cnt <= sat_inc(pass_cnt);
        else       fail_cnt <= sat_inc(fail_cnt);
      end
      st_p1 <= st_nxt;
      err   <= (st_nxt == FAILED);
    end
  end

  assign state = st_p1;

`ifdef OR_CHECKER_CAPTURE_EN
  // Only the first failure since reset/clear is latched
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      first_res   <= '0;
      first_exp   <= '0;
    end else if (accept_p0 && !ok_p0 && !first_valid) begin
      first_valid <= 1'b1;
      first_a     <= bus.in_a;
      first_b     <= bus.in_b;
      first_res   <= bus.in_res;
      first_exp   <= exp_p0;
    end
  end
`else
  assign first_valid = 1'b0;
  assign first_a     = '0;
  assign first_b     = '0;
  assign first_res   = '0;
  assign first_exp   = '0;
`endif

endmodule
